// File: rtl/uart_rx_line_con_if.sv
// Byte-in / line-out bundle between the UART receiver, the line assembler and its consumer.
// master = receiver + consumer side, slave = the assembler.
interface uart_rx_line_con_if;
    logic [7:0]  rbus;
    logic        rvalid;
    logic        rack;
    logic [31:0] rbuf;
    logic [2:0]  bcount;
    logic        line_valid;
    logic        ovf;
    logic        overrun;
    logic        tmo;

    modport master (
        output rbus, rvalid, rack,
        input  rbuf, bcount, line_valid, ovf, overrun, tmo
    );

    modport slave (
        input  rbus, rvalid, rack,
        output rbuf, bcount, line_valid, ovf, overrun, tmo
    );
endinterface

// File: rtl/uart_rx_line_con.sv
// Packs up to four received data bytes into a 32-bit word per CR-terminated line and
// holds the line until acknowledged; spaces/LF are skipped, stale partial lines time out.
module uart_rx_line_con #(
    parameter int unsigned TIMEOUT   = 0,
    parameter logic [7:0]  TERM_CHAR = 8'd13
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_rx_line_con_if.slave lbus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    localparam int unsigned      CW      = (TIMEOUT < 32'd2) ? 1 : $clog2(TIMEOUT + 32'd1);
    localparam logic [CW-1:0]    TMO_MAX = CW'(TIMEOUT);

    logic [1:0]    state_r,      state_s;
    logic [31:0]   rbuf_r,       rbuf_s;
    logic [2:0]    count_r,      count_s;
    logic [2:0]    bcount_r,     bcount_s;
    logic          line_valid_r, line_valid_s;
    logic          ovf_r,        ovf_s;
    logic          overrun_r,    overrun_s;
    logic          tmo_r,        tmo_s;
    logic [CW-1:0] idle_cnt_r,   idle_cnt_s;

    logic          is_ign_s;
    logic          is_term_s;
    logic          is_data_s;
    logic          acked_s;
    logic          tmo_hit_s;
    logic [1:0]    st_eff_s;

    // Byte classification, idle counter and the acknowledge-wins state override.
    always_comb begin
        is_ign_s  = (lbus.rbus == 8'd10) || (lbus.rbus == 8'd32);
        is_term_s = !is_ign_s && (lbus.rbus == TERM_CHAR);
        is_data_s = !is_ign_s && !is_term_s;
        acked_s   = (state_r == ST_HOLD) && lbus.rack;
        st_eff_s  = acked_s ? ST_IDLE : state_r;

        if (lbus.rvalid) begin
            idle_cnt_s = {CW{1'b0}};
        end else if (idle_cnt_r == TMO_MAX) begin
            idle_cnt_s = idle_cnt_r;
        end else begin
            idle_cnt_s = idle_cnt_r + CW'(1);
        end
        tmo_hit_s = (TIMEOUT != 32'd0) && !lbus.rvalid && (idle_cnt_s == TMO_MAX);
    end

    // Next-state and datapath for the IDLE / COLLECT / HOLD line machine.
    always_comb begin
        state_s      = st_eff_s;
        rbuf_s       = rbuf_r;
        count_s      = count_r;
        bcount_s     = bcount_r;
        line_valid_s = line_valid_r;
        ovf_s        = ovf_r;
        overrun_s    = overrun_r;
        tmo_s        = 1'b0;

        if (acked_s) begin
            line_valid_s = 1'b0;
            overrun_s    = 1'b0;
        end else begin
            line_valid_s = line_valid_r;
        end

        case (st_eff_s)
            ST_IDLE: begin
                // A bare terminator from IDLE is ignored so empty lines never complete.
                if (lbus.rvalid && is_data_s) begin
                    rbuf_s  = {24'd0, lbus.rbus};
                    count_s = 3'd1;
                    ovf_s   = 1'b0;
                    state_s = ST_COLLECT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (lbus.rvalid) begin
                    if (is_data_s) begin
                        if (count_r < 3'd4) begin
                            rbuf_s  = {rbuf_r[23:0], lbus.rbus};
                            count_s = count_r + 3'd1;
                        end else begin
                            ovf_s   = 1'b1;
                        end
                    end else if (is_term_s) begin
                        bcount_s     = count_r;
                        line_valid_s = 1'b1;
                        state_s      = ST_HOLD;
                    end else begin
                        state_s = ST_COLLECT;
                    end
                end else if (tmo_hit_s) begin
                    tmo_s   = 1'b1;
                    count_s = 3'd0;
                    ovf_s   = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_COLLECT;
                end
            end
            ST_HOLD: begin
                if (lbus.rvalid) begin
                    overrun_s = 1'b1;
                end else begin
                    overrun_s = overrun_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops all line content immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            rbuf_r       <= 32'd0;
            count_r      <= 3'd0;
            bcount_r     <= 3'd0;
            line_valid_r <= 1'b0;
            ovf_r        <= 1'b0;
            overrun_r    <= 1'b0;
            tmo_r        <= 1'b0;
            idle_cnt_r   <= {CW{1'b0}};
        end else begin
            state_r      <= state_s;
            rbuf_r       <= rbuf_s;
            count_r      <= count_s;
            bcount_r     <= bcount_s;
            line_valid_r <= line_valid_s;
            ovf_r        <= ovf_s;
            overrun_r    <= overrun_s;
            tmo_r        <= tmo_s;
            idle_cnt_r   <= idle_cnt_s;
        end
    end

    assign lbus.rbuf       = rbuf_r;
    assign lbus.bcount     = bcount_r;
    assign lbus.line_valid = line_valid_r;
    assign lbus.ovf        = ovf_r;
    assign lbus.overrun    = overrun_r;
    assign lbus.tmo        = tmo_r;

endmodule

// File: tb/tb_uart_rx_line_con.sv
// Directed bench for uart_rx_line_con: a queue-based line model checked every cycle,
// plus literal expectations taken from worked examples.
module tb_uart_rx_line_con;

    localparam int TMO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_rx_line_con_if lbus ();

    uart_rx_line_con #(.TIMEOUT(TMO), .TERM_CHAR(8'd13)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .lbus (lbus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Line model: mode 0 idle, 1 collecting, 2 holding; m_q keeps the accepted data bytes.
    logic [7:0] m_q[$];
    int         m_mode;
    int         m_timer;
    logic       m_lv, m_ovf, m_ovr, m_tmo, m_known;
    logic [2:0] m_bcount;

    function automatic logic [31:0] packed_line();
        logic [31:0] r = 32'd0;
        foreach (m_q[i]) r = {r[23:0], m_q[i]};
        return r;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_mode = 0; m_timer = 0;
        m_lv = 1'b0; m_ovf = 1'b0; m_ovr = 1'b0; m_tmo = 1'b0; m_known = 1'b1;
        m_bcount = 3'd0;
    endtask

    task automatic model_step(input logic [7:0] b, input logic rv, input logic ra);
        int pre = m_mode;
        m_tmo = 1'b0;
        if (m_mode == 2 && ra) begin
            m_lv = 1'b0; m_ovr = 1'b0; m_mode = 0;
        end else if (m_mode == 2 && rv) begin
            m_ovr = 1'b1;
        end
        if (m_mode != 2 && rv && b != 8'd10 && b != 8'd32) begin
            if (b == 8'd13) begin
                if (m_mode == 1) begin
                    m_bcount = 3'(m_q.size()); m_lv = 1'b1; m_mode = 2;
                end
            end else if (m_mode == 0) begin
                m_q.delete(); m_q.push_back(b);
                m_ovf = 1'b0; m_known = 1'b1; m_mode = 1;
            end else if (m_q.size() < 4) begin
                m_q.push_back(b);
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (rv) m_timer = 0;
        else if (m_timer < TMO) m_timer++;
        if (pre == 1 && !rv && m_timer == TMO) begin
            m_tmo = 1'b1; m_ovf = 1'b0; m_known = 1'b0; m_q.delete(); m_mode = 0;
        end
    endtask

    // Compare DUT against the model on every falling edge, then advance the model
    // with the inputs the next rising edge will sample.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            chk("line_valid", 32'(lbus.line_valid), 32'(m_lv));
            chk("ovf",        32'(lbus.ovf),        32'(m_ovf));
            chk("overrun",    32'(lbus.overrun),    32'(m_ovr));
            chk("tmo",        32'(lbus.tmo),        32'(m_tmo));
            if (m_known) chk("rbuf", lbus.rbuf, packed_line());
            if (m_lv)    chk("bcount", 32'(lbus.bcount), 32'(m_bcount));
            if (rst_n) model_step(lbus.rbus, lbus.rvalid, lbus.rack);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] b);
        lbus.rbus = b; lbus.rvalid = 1'b1;
        tick();
        lbus.rvalid = 1'b0;
    endtask

    task automatic ack();
        lbus.rack = 1'b1;
        tick();
        lbus.rack = 1'b0;
    endtask

    task automatic ack_with(input logic [7:0] b);
        lbus.rack = 1'b1; lbus.rbus = b; lbus.rvalid = 1'b1;
        tick();
        lbus.rack = 1'b0; lbus.rvalid = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_rbuf"},   lbus.rbuf, 32'd0);
        chk({name, "_bcount"}, 32'(lbus.bcount), 32'd0);
        chk({name, "_lv"},     32'(lbus.line_valid), 32'd0);
        chk({name, "_ovf"},    32'(lbus.ovf), 32'd0);
        chk({name, "_ovr"},    32'(lbus.overrun), 32'd0);
        chk({name, "_tmo"},    32'(lbus.tmo), 32'd0);
    endtask

    task automatic async_reset(input string name);
        #2 rst_n = 1'b0;
        #1 chk_all_zero(name);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        lbus.rbus = 8'd0; lbus.rvalid = 1'b0; lbus.rack = 1'b0;
        #2 chk_all_zero("reset");
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // "AB CD" CR
        send(8'h41); send(8'h42); send(8'h20); send(8'h43); send(8'h44); send(8'd13);
        chk("abcd_lv", 32'(lbus.line_valid), 32'd1);
        chk("abcd_rbuf", lbus.rbuf, 32'h41424344);
        chk("abcd_bcount", 32'(lbus.bcount), 32'd4);
        chk("abcd_ovf", 32'(lbus.ovf), 32'd0);
        ack();
        chk("abcd_ack_lv", 32'(lbus.line_valid), 32'd0);

        // "12" LF CR, then an empty line
        send(8'h31); send(8'h32); send(8'd10); send(8'd13);
        chk("12_rbuf", lbus.rbuf, 32'h00003132);
        chk("12_bcount", 32'(lbus.bcount), 32'd2);
        ack();
        send(8'd13); tick(); tick();
        chk("empty_lv", 32'(lbus.line_valid), 32'd0);

        // six data bytes: overflow
        for (int i = 0; i < 6; i++) send(8'(8'h31 + i));
        send(8'd13);
        chk("ovf_rbuf", lbus.rbuf, 32'h31323334);
        chk("ovf_bcount", 32'(lbus.bcount), 32'd4);
        chk("ovf_flag", 32'(lbus.ovf), 32'd1);
        ack();
        send(8'h37); send(8'd13);
        chk("7_ovf", 32'(lbus.ovf), 32'd0);
        chk("7_rbuf", lbus.rbuf, 32'h00000037);

        // overrun while held, then ack coincident with a new data byte
        send(8'h58); send(8'h59);
        chk("ovr_flag", 32'(lbus.overrun), 32'd1);
        chk("ovr_rbuf", lbus.rbuf, 32'h00000037);
        ack_with(8'h5A);
        chk("ackz_ovr", 32'(lbus.overrun), 32'd0);
        chk("ackz_lv", 32'(lbus.line_valid), 32'd0);
        chk("ackz_rbuf", lbus.rbuf, 32'h0000005A);
        send(8'd13);
        chk("z_bcount", 32'(lbus.bcount), 32'd1);
        ack();

        // timeout of a partial line
        send(8'h41);
        for (int i = 1; i <= TMO; i++) begin
            tick();
            chk("tmo_cycle", 32'(lbus.tmo), (i == TMO) ? 32'd1 : 32'd0);
        end
        tick();
        chk("tmo_after", 32'(lbus.tmo), 32'd0);
        chk("tmo_lv", 32'(lbus.line_valid), 32'd0);
        send(8'h42); send(8'd13);
        chk("b_rbuf", lbus.rbuf, 32'h00000042);
        chk("b_bcount", 32'(lbus.bcount), 32'd1);
        ack();

        // reset mid-line, then reset while holding with overrun set
        send(8'h41); send(8'h42);
        async_reset("rst_collect");
        repeat (TMO + 4) tick();
        send(8'h43); send(8'h44); send(8'd13); send(8'h58);
        chk("pre_rst_ovr", 32'(lbus.overrun), 32'd1);
        async_reset("rst_hold");
        tick();
        send(8'h45); send(8'h46); send(8'd13);
        chk("ef_rbuf", lbus.rbuf, 32'h00004546);
        chk("ef_bcount", 32'(lbus.bcount), 32'd2);
        chk("ef_lv", 32'(lbus.line_valid), 32'd1);
        ack();
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
